// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Lets two requesters share the single-port data memory. Port 0 is the CPU
// load/store path and port 1 is the debug/DMA path. Each port raises req and
// holds its command until a one-cycle done pulse comes back. Each access
// walks IDLE -> ACCESS -> RESP, so one transaction takes three cycles.
// Simultaneous requests are granted round-robin. Addresses at or above DEPTH
// are rejected: no memory strobe is issued, and err is flagged with done.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN, weN, addrN, wdataN   port N command (N = 0, 1), held until doneN
//   doneN, errN                port N completion pulse and out-of-range flag
//   rdataN                     port N read data, held until its next read
//   mem_write, mem_read        memory strobes, high only during ACCESS
//   mem_addr, mem_wdata        memory address / write data, zero when idle
//   mem_rdata                  combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    state_t              state_q,      state_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q,      owner_d;
    logic                oor_q,        oor_d;
    logic                mem_write_q,  mem_write_d;
    logic                mem_read_q,   mem_read_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic                done0_q,      done0_d;
    logic                done1_q,      done1_d;
    logic                err0_q,       err0_d;
    logic                err1_q,       err1_d;
    logic [DATA_W-1:0]   rdata0_q,     rdata0_d;
    logic [DATA_W-1:0]   rdata1_q,     rdata1_d;

    logic                grant_port;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_in_range;

    // A lone requester always wins. On a tie, the port that did not own the
    // previous grant wins.
    always_comb begin
        grant_port   = (req0 && req1) ? ~last_owner_q : req1;
        sel_we       = grant_port ? we1    : we0;
        sel_addr     = grant_port ? addr1  : addr0;
        sel_wdata    = grant_port ? wdata1 : wdata0;
        sel_in_range = ({1'b0, sel_addr} < DEPTH_LIM);
    end

    // Next-state and registered-output logic. The strobes, address and write
    // data are computed at grant time, so they appear as flop outputs for
    // exactly the ACCESS cycle. done/err default low, which makes them
    // single-cycle pulses.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        oor_d        = oor_q;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d      = ACCESS;
                    owner_d      = grant_port;
                    last_owner_d = grant_port;
                    oor_d        = ~sel_in_range;
                    mem_write_d  = sel_we & sel_in_range;
                    mem_read_d   = ~sel_we & sel_in_range;
                    mem_addr_d   = sel_addr;
                    mem_wdata_d  = sel_wdata;
                end
            end

            ACCESS: begin
                state_d = RESP;
                // mem_read_q is only set for an in-range read, so an
                // out-of-range read leaves the held read data untouched.
                if (mem_read_q) begin
                    if (owner_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end
                done0_d = ~owner_q;
                done1_d = owner_q;
                err0_d  = ~owner_q & oor_q;
                err1_d  = owner_q & oor_q;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_owner resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            oor_q        <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            oor_q        <= oor_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed and randomised checks of dmem_arbiter against a small behavioural
// data memory and a reference memory model kept by the bench.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req0, we0, req1, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              done0, err0, done1, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_write, mem_read;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   int checkCount = 0;
   int passCount  = 0;
   int writePulses = 0;
   int readPulses  = 0;
   int bothHigh    = 0;

   logic [DATA_W-1:0] memArray [DEPTH];
   logic [DATA_W-1:0] refMem   [DEPTH];

   dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .we0       (we0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .done0     (done0),
      .err0      (err0),
      .rdata0    (rdata0),
      .req1      (req1),
      .we1       (we1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .done1     (done1),
      .err1      (err1),
      .rdata1    (rdata1),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Behavioural single-port memory: combinational read, write on the edge.
   assign mem_rdata = (mem_addr < ADDR_W'(DEPTH)) ? memArray[mem_addr[1:0]] : '0;

   always @(posedge clk) begin
      if (mem_write && (mem_addr < ADDR_W'(DEPTH)))
         memArray[mem_addr[1:0]] <= mem_wdata;
   end

   // Strobe monitor sampled mid-cycle
   always @(negedge clk) begin
      if (mem_write) writePulses <= writePulses + 1;
      if (mem_read)  readPulses  <= readPulses + 1;
      if (mem_write && mem_read) bothHigh <= bothHigh + 1;
   end

   // Safety net in case the design stops responding altogether
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not reach the end");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int port, input logic req, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
      if (port == 0) begin
         req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      setReq(0, 1'b0, 1'b0, '0, '0);
      setReq(1, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Single-port transaction: raise req, wait for done (bounded), drop req,
   // and leave one idle cycle so the FSM is back in IDLE on return.
   task automatic applyStimulus(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rdata,
                                output logic err, output int lat);
      lat = 0;
      setReq(port, 1'b1, we, addr, wdata);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if ((port == 0) ? done0 : done1) begin
            lat = i;
            break;
         end
      end
      rdata = (port == 0) ? rdata0 : rdata1;
      err   = (port == 0) ? err0 : err1;
      setReq(port, 1'b0, 1'b0, '0, '0);
      if (lat == 0) checkOutput("done timeout", 0, 1);
      tick();
   endtask

   initial begin
      logic [DATA_W-1:0] rd;
      logic              er;
      int                lat;
      int                snapW, snapR;

      rst_n = 1'b0;
      setReq(0, 1'b0, 1'b0, '0, '0);
      setReq(1, 1'b0, 1'b0, '0, '0);
      #3;

      // ---- reset values while reset is held ----
      checkOutput("rst done0",     32'(done0),     0);
      checkOutput("rst done1",     32'(done1),     0);
      checkOutput("rst err0",      32'(err0),      0);
      checkOutput("rst err1",      32'(err1),      0);
      checkOutput("rst mem_write", 32'(mem_write), 0);
      checkOutput("rst mem_read",  32'(mem_read),  0);
      checkOutput("rst mem_addr",  32'(mem_addr),  0);
      checkOutput("rst mem_wdata", mem_wdata,      0);
      checkOutput("rst rdata0",    rdata0,         0);
      checkOutput("rst rdata1",    rdata1,         0);
      tick();
      rst_n = 1'b1;
      tick();

      // ---- test 1: port 0 write then read of addr 2 ----
      $display("[TB] test 1: port 0 write/read");
      snapW = writePulses;
      setReq(0, 1'b1, 1'b1, 6'd2, 32'hDEADBEEF);
      tick();
      checkOutput("t1 mem_write in ACCESS", 32'(mem_write), 1);
      checkOutput("t1 mem_read in ACCESS",  32'(mem_read),  0);
      checkOutput("t1 mem_addr",            32'(mem_addr),  2);
      checkOutput("t1 mem_wdata",           mem_wdata,      32'hDEADBEEF);
      checkOutput("t1 done0 early",         32'(done0),     0);
      tick();
      checkOutput("t1 write done0",         32'(done0),     1);
      checkOutput("t1 write err0",          32'(err0),      0);
      checkOutput("t1 mem_write after",     32'(mem_write), 0);
      checkOutput("t1 mem_addr idle",       32'(mem_addr),  0);
      setReq(0, 1'b0, 1'b0, '0, '0);
      tick();
      checkOutput("t1 single write pulse",  32'(writePulses - snapW), 1);
      applyStimulus(0, 1'b0, 6'd2, 32'h0, rd, er, lat);
      checkOutput("t1 read rdata0",  rd,        32'hDEADBEEF);
      checkOutput("t1 read latency", 32'(lat),  2);
      checkOutput("t1 read err0",    32'(er),   0);

      // ---- test 2: simultaneous requests alternate ----
      $display("[TB] test 2: round-robin tie");
      doReset();
      begin
         int donePort [4];
         int doneTick [4];
         int n = 0, cnt0 = 0, cnt1 = 0, dual = 0;
         setReq(0, 1'b1, 1'b1, 6'd0, 32'h11110000);
         setReq(1, 1'b1, 1'b1, 6'd1, 32'h22220001);
         for (int t = 1; t <= 14; t++) begin
            tick();
            if (done0 && done1) dual++;
            if (done0) begin
               if (n < 4) begin donePort[n] = 0; doneTick[n] = t; end
               n++;
               cnt0++;
               if (cnt0 == 2) setReq(0, 1'b0, 1'b0, '0, '0);
            end
            if (done1) begin
               if (n < 4) begin donePort[n] = 1; doneTick[n] = t; end
               n++;
               cnt1++;
               if (cnt1 == 2) setReq(1, 1'b0, 1'b0, '0, '0);
            end
         end
         setReq(0, 1'b0, 1'b0, '0, '0);
         setReq(1, 1'b0, 1'b0, '0, '0);
         checkOutput("t2 done count", 32'(n),    4);
         checkOutput("t2 dual done",  32'(dual), 0);
         for (int i = 0; i < 4 && i < n; i++) begin
            checkOutput($sformatf("t2 grant %0d port", i), 32'(donePort[i]), 32'(i % 2));
            checkOutput($sformatf("t2 grant %0d tick", i), 32'(doneTick[i]), 32'(2 + 3 * i));
         end
      end
      tick();

      // ---- test 3: out-of-range read on port 1 ----
      $display("[TB] test 3: out-of-range read");
      applyStimulus(1, 1'b0, 6'd1, 32'h0, rd, er, lat);
      checkOutput("t3 prior read rdata1", rd, 32'h22220001);
      snapW = writePulses;
      snapR = readPulses;
      applyStimulus(1, 1'b0, 6'd5, 32'h0, rd, er, lat);
      checkOutput("t3 err1",           32'(er),  1);
      checkOutput("t3 rdata1 held",    rd,       32'h22220001);
      checkOutput("t3 latency",        32'(lat), 2);
      checkOutput("t3 no read strobe", 32'(readPulses - snapR),  0);
      checkOutput("t3 no write strobe",32'(writePulses - snapW), 0);

      // ---- test 4: req dropped during ACCESS still completes once ----
      $display("[TB] test 4: drop req during ACCESS");
      snapW = writePulses;
      setReq(0, 1'b1, 1'b1, 6'd3, 32'hC0FFEE03);
      tick();
      checkOutput("t4 mem_write", 32'(mem_write), 1);
      setReq(0, 1'b0, 1'b0, '0, '0);
      tick();
      checkOutput("t4 done0", 32'(done0), 1);
      begin
         int extra = 0;
         for (int t = 0; t < 4; t++) begin
            tick();
            if (done0 || mem_write || mem_read) extra++;
         end
         checkOutput("t4 no second access", 32'(extra), 0);
      end
      checkOutput("t4 one write pulse", 32'(writePulses - snapW), 1);

      // ---- test 5: reset in the middle of a port-1 write ----
      $display("[TB] test 5: reset during ACCESS");
      setReq(1, 1'b1, 1'b1, 6'd0, 32'h5555AAAA);
      tick();
      checkOutput("t5 strobe before reset", 32'(mem_write), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5 mem_write cleared", 32'(mem_write), 0);
      checkOutput("t5 mem_read cleared",  32'(mem_read),  0);
      checkOutput("t5 rdata1 cleared",    rdata1,         0);
      setReq(1, 1'b0, 1'b0, '0, '0);
      begin
         int seen = 0;
         for (int t = 0; t < 3; t++) begin
            tick();
            if (done1 || done0) seen++;
         end
         rst_n = 1'b1;
         tick();
         if (done1 || done0) seen++;
         checkOutput("t5 no done after reset", 32'(seen), 0);
      end
      begin
         int firstPort = -1;
         int got1 = 0;
         setReq(0, 1'b1, 1'b0, 6'd3, 32'h0);
         setReq(1, 1'b1, 1'b0, 6'd3, 32'h0);
         for (int t = 0; t < 8 && firstPort < 0; t++) begin
            tick();
            if (done0) firstPort = 0;
            else if (done1) firstPort = 1;
         end
         checkOutput("t5 first tie winner", 32'(firstPort), 0);
         checkOutput("t5 rdata0",           rdata0,         32'hC0FFEE03);
         setReq(0, 1'b0, 1'b0, '0, '0);
         for (int t = 0; t < 8 && got1 == 0; t++) begin
            tick();
            if (done1) got1 = 1;
         end
         checkOutput("t5 port 1 served", 32'(got1), 1);
         checkOutput("t5 rdata1",        rdata1,    32'hC0FFEE03);
         setReq(1, 1'b0, 1'b0, '0, '0);
         tick();
      end

      // ---- test 6: random traffic on both ports against a reference model ----
      $display("[TB] test 6: random traffic");
      doReset();
      for (int a = 0; a < DEPTH; a++) begin
         refMem[a] = $urandom;
         applyStimulus(0, 1'b1, ADDR_W'(a), refMem[a], rd, er, lat);
      end
      begin
         logic              act   [2];
         logic              tWe   [2];
         logic [ADDR_W-1:0] tAddr [2];
         logic [DATA_W-1:0] tData [2];
         logic [DATA_W-1:0] prevRd[2];
         int                waitCnt[2];
         int                issued = 0, completed = 0, maxWait = 0;
         logic [DATA_W-1:0] expRd;
         logic              inRange;
         act[0] = 1'b0; act[1] = 1'b0;
         prevRd[0] = rdata0; prevRd[1] = rdata1;
         waitCnt[0] = 0; waitCnt[1] = 0;
         for (int cyc = 0; cyc < 5000 && completed < 200; cyc++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
               if (act[p]) begin
                  waitCnt[p]++;
                  if ((p == 0) ? done0 : done1) begin
                     inRange = (tAddr[p] < ADDR_W'(DEPTH));
                     checkOutput($sformatf("t6 p%0d err", p), 32'((p == 0) ? err0 : err1), 32'(!inRange));
                     if (!tWe[p]) begin
                        expRd = inRange ? refMem[tAddr[p][1:0]] : prevRd[p];
                        checkOutput($sformatf("t6 p%0d rdata", p), (p == 0) ? rdata0 : rdata1, expRd);
                        prevRd[p] = expRd;
                     end else if (inRange) begin
                        refMem[tAddr[p][1:0]] = tData[p];
                     end
                     if (waitCnt[p] > maxWait) maxWait = waitCnt[p];
                     act[p] = 1'b0;
                     setReq(p, 1'b0, 1'b0, '0, '0);
                     completed++;
                  end
               end else if (issued < 200 && $urandom_range(0, 3) != 0) begin
                  tWe[p]   = 1'($urandom_range(0, 1));
                  tAddr[p] = 6'($urandom_range(0, 5));
                  tData[p] = $urandom;
                  setReq(p, 1'b1, tWe[p], tAddr[p], tData[p]);
                  act[p]     = 1'b1;
                  waitCnt[p] = 0;
                  issued++;
               end
            end
         end
         checkOutput("t6 completed", 32'(completed), 200);
         checkOutput("t6 max wait within 6", 32'(maxWait <= 6), 1);
         setReq(0, 1'b0, 1'b0, '0, '0);
         setReq(1, 1'b0, 1'b0, '0, '0);
      end
      tick();
      checkOutput("both strobes never high", 32'(bothHigh), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
